// File: rtl/kbd_scan_ctrl_pkg.sv
// Shared keyboard-scan definitions for the POKEY core: debounce state encoding,
// default SHIFT/CTRL scan codes and KBCODE field layout.
package kbd_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_WAIT     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } kbd_state_t;

   localparam logic [5:0] SHIFT_CODE_DEF = 6'h10;
   localparam logic [5:0] CTRL_CODE_DEF  = 6'h00;

   localparam int KB_CTRL_BIT  = 7;
   localparam int KB_SHIFT_BIT = 6;
   localparam int KB_CODE_MSB  = 5;

   function automatic logic [7:0] pack_kbcode(input logic ctrl, input logic shift,
                                              input logic [5:0] code);
      logic [7:0] k;
      k                  = 8'h00;
      k[KB_CTRL_BIT]     = ctrl;
      k[KB_SHIFT_BIT]    = shift;
      k[KB_CODE_MSB:0]   = code;
      return k;
   endfunction

endpackage

// File: rtl/kbd_scan_ctrl_if.sv
// Keyboard scan bundle: scan-rate tick, SKCTL enables, key return lines and
// the KBCODE/SKSTAT/IRQ results; state is exposed for debug.
interface kbd_scan_ctrl_if;
   import kbd_scan_ctrl_pkg::*;

   // Inputs are level signals sampled on the falling clk edge; irqAck is a
   // single-clk pulse that needs no enn qualification.
   logic       enn;
   logic       scanEn;
   logic       debounceEn;
   logic       kr1_n;
   logic       kr2_n;
   logic       irqAck;
   logic [5:0] kOut;
   logic [7:0] kbcode;
   logic       keyDown;
   logic       kShift;
   logic       keyOvrun;
   logic       kbIrq;
   kbd_state_t state;

   modport master (
      output enn, scanEn, debounceEn, kr1_n, kr2_n, irqAck,
      input  kOut, kbcode, keyDown, kShift, keyOvrun, kbIrq, state
   );

   modport slave (
      input  enn, scanEn, debounceEn, kr1_n, kr2_n, irqAck,
      output kOut, kbcode, keyDown, kShift, keyOvrun, kbIrq, state
   );

endinterface

// File: rtl/kbd_scan_ctrl_cnt.sv
// 6-bit keyboard scan address counter: advances on each enn tick while run=1,
// wraps 63->0, and is held at zero while run=0.
module kbd_scan_cnt (
   input  logic       clk,
   input  logic       reset,
   input  logic       enn,
   input  logic       run,
   output logic [5:0] count
);

   always_ff @(negedge clk) begin
      if (reset) begin
         count <= 6'd0;
      end else if (enn) begin
         count <= run ? count + 6'd1 : 6'd0;
      end
   end

endmodule

// File: rtl/kbd_scan_ctrl.sv
// POKEY keyboard scan sequencer: drives the scan address, debounces KR1,
// latches KBCODE with SHIFT/CTRL and raises the keyboard IRQ / overrun status.
module kbd_scan_ctrl
   import kbd_scan_ctrl_pkg::*;
#(
   parameter logic [5:0] SHIFT_CODE = SHIFT_CODE_DEF,
   parameter logic [5:0] CTRL_CODE  = CTRL_CODE_DEF
) (
   input logic          clk,
   input logic          reset,
   kbd_scan_ctrl_if.slave kbd
);

   logic [5:0] k_out;
   kbd_state_t state_q, state_n;
   logic [5:0] cmp_q, cmp_n;
   logic [7:0] kbcode_q, kbcode_n;
   logic       kshift_q, kshift_n;
   logic       ctrl_q, ctrl_n;
   logic       ovrun_q, ovrun_n;
   logic       irq_q, irq_n;
   logic       accept;
   logic [5:0] code;
   logic       hit;
   logic       key;

   kbd_scan_cnt u_cnt (
      .clk   (clk),
      .reset (reset),
      .enn   (kbd.enn),
      .run   (kbd.scanEn),
      .count (k_out)
   );

   assign hit = (k_out == cmp_q);
   assign key = ~kbd.kr1_n;

   always_comb begin
      state_n  = state_q;
      cmp_n    = cmp_q;
      kbcode_n = kbcode_q;
      kshift_n = kshift_q;
      ctrl_n   = ctrl_q;
      ovrun_n  = ovrun_q;
      irq_n    = irq_q;
      accept   = 1'b0;
      code     = k_out;

      if (kbd.enn) begin
         ovrun_n = 1'b0;
         if (!kbd.scanEn) begin
            state_n  = ST_WAIT;
            kshift_n = 1'b0;
         end else begin
            if (k_out == SHIFT_CODE) kshift_n = ~kbd.kr2_n;
            if (k_out == CTRL_CODE)  ctrl_n   = ~kbd.kr2_n;
            // Once a key is tracked, only its own scan slot (cmp) is looked at.
            case (state_q)
               ST_WAIT: begin
                  if (key) begin
                     if (kbd.debounceEn) begin
                        cmp_n   = k_out;
                        state_n = ST_DEBOUNCE;
                     end else begin
                        accept  = 1'b1;
                        code    = k_out;
                        state_n = ST_HELD;
                     end
                  end
               end
               ST_DEBOUNCE: begin
                  if (hit) begin
                     if (key) begin
                        accept  = 1'b1;
                        code    = cmp_q;
                        state_n = ST_HELD;
                     end else begin
                        state_n = ST_WAIT;
                     end
                  end
               end
               ST_HELD: begin
                  if (hit && !key) state_n = kbd.debounceEn ? ST_RELEASE : ST_WAIT;
               end
               ST_RELEASE: begin
                  if (hit) state_n = key ? ST_HELD : ST_WAIT;
               end
               default: state_n = ST_WAIT;
            endcase
         end
      end

      if (kbd.irqAck) irq_n = 1'b0;

      // A fresh key beats a simultaneous acknowledge.
      if (accept) begin
         kbcode_n = pack_kbcode(ctrl_q, kshift_q, code);
         cmp_n    = code;
         ovrun_n  = irq_q & ~kbd.irqAck;
         irq_n    = 1'b1;
      end
   end

   always_ff @(negedge clk) begin
      if (reset) begin
         state_q  <= ST_WAIT;
         cmp_q    <= 6'd0;
         kbcode_q <= 8'h00;
         kshift_q <= 1'b0;
         ctrl_q   <= 1'b0;
         ovrun_q  <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_n;
         cmp_q    <= cmp_n;
         kbcode_q <= kbcode_n;
         kshift_q <= kshift_n;
         ctrl_q   <= ctrl_n;
         ovrun_q  <= ovrun_n;
         irq_q    <= irq_n;
      end
   end

   assign kbd.kOut     = k_out;
   assign kbd.kbcode   = kbcode_q;
   assign kbd.keyDown  = (state_q == ST_HELD) || (state_q == ST_RELEASE);
   assign kbd.kShift   = kshift_q;
   assign kbd.keyOvrun = ovrun_q;
   assign kbd.kbIrq    = irq_q;
   assign kbd.state    = state_q;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Directed bench for kbd_scan_ctrl: a table of key actions with hand-computed
// results, followed by scanEn-drop, reset, CTRL and bare-irqAck sequences.
module tb_kbd_scan_ctrl;
   import kbd_scan_ctrl_pkg::*;

   logic clk;
   logic reset;
   kbd_scan_ctrl_if kif ();

   kbd_scan_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .kbd   (kif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [1:0] op;       // 0 none, 1 press key, 2 release key
      logic [5:0] key;
      logic       ack;
      logic       dbn;
      logic       shift;
      logic [5:0] upto;
      logic [1:0] e_state;
      logic [7:0] e_kbcode;
      logic       e_kd;
      logic       e_ks;
      logic       e_irq;
      logic       e_ovr;
   } vec_t;

   localparam int NVEC = 32;
   vec_t vecs [NVEC];

   logic [63:0] keys;
   logic [5:0]  k_model;
   logic        shift_on, ctrl_on, dbn_on, scan_en, rst_on;
   int          n_chk, n_fail;

   function automatic vec_t mk(input string n, input logic [1:0] op, input logic [5:0] key,
                               input logic ack, input logic dbn, input logic sh,
                               input logic [5:0] upto, input logic [1:0] st,
                               input logic [7:0] kc, input logic kd, input logic ks,
                               input logic irq, input logic ovr);
      vec_t v;
      v.name = n; v.op = op; v.key = key; v.ack = ack; v.dbn = dbn; v.shift = sh;
      v.upto = upto; v.e_state = st; v.e_kbcode = kc; v.e_kd = kd; v.e_ks = ks;
      v.e_irq = irq; v.e_ovr = ovr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string nm, input logic [1:0] st, input logic [7:0] kc,
                            input logic kd, input logic ks, input logic irq,
                            input logic ovr, input logic [5:0] ko);
      chk({nm, ".state"},    32'(kif.state),    32'(st));
      chk({nm, ".kbcode"},   32'(kif.kbcode),   32'(kc));
      chk({nm, ".keyDown"},  32'(kif.keyDown),  32'(kd));
      chk({nm, ".kShift"},   32'(kif.kShift),   32'(ks));
      chk({nm, ".kbIrq"},    32'(kif.kbIrq),    32'(irq));
      chk({nm, ".keyOvrun"}, 32'(kif.keyOvrun), 32'(ovr));
      chk({nm, ".kOut"},     32'(kif.kOut),     32'(ko));
   endtask

   // Drives one clk cycle; the keyboard matrix answers for the bench's own scan address.
   task automatic cyc(input logic e, input logic ack);
      @(posedge clk);
      kif.enn        = e;
      kif.irqAck     = ack;
      kif.scanEn     = scan_en;
      kif.debounceEn = dbn_on;
      kif.kr1_n      = ~keys[k_model];
      kif.kr2_n      = ~(((k_model == 6'h10) && shift_on) || ((k_model == 6'h00) && ctrl_on));
      reset          = rst_on;
      @(negedge clk);
      #1;
      if (rst_on)  k_model = 6'd0;
      else if (e)  k_model = scan_en ? k_model + 6'd1 : 6'd0;
      kif.enn    = 1'b0;
      kif.irqAck = 1'b0;
   endtask

   // Ticks until the scan slot 'upto' has just been sampled.
   task automatic run_to(input logic [5:0] upto, input logic ack);
      logic a;
      a = ack;
      while (k_model != upto) begin
         cyc(1'b1, a);
         a = 1'b0;
      end
      cyc(1'b1, a);
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      keys = '0; k_model = 6'd0;
      shift_on = 1'b1; ctrl_on = 1'b0; dbn_on = 1'b1; scan_en = 1'b1; rst_on = 1'b1;
      reset = 1'b1;
      kif.enn = 1'b0; kif.scanEn = 1'b1; kif.debounceEn = 1'b1;
      kif.kr1_n = 1'b1; kif.kr2_n = 1'b1; kif.irqAck = 1'b0;

      vecs[0]  = mk("dbn_press",     2'd1, 6'h1A, 1'b0, 1'b1, 1'b1, 6'h1A, ST_DEBOUNCE, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      vecs[1]  = mk("dbn_wait63",    2'd0, 6'h1A, 1'b0, 1'b1, 1'b1, 6'h19, ST_DEBOUNCE, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      vecs[2]  = mk("dbn_accept",    2'd0, 6'h1A, 1'b0, 1'b1, 1'b1, 6'h1A, ST_HELD,     8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
      vecs[3]  = mk("rel_first",     2'd2, 6'h1A, 1'b0, 1'b1, 1'b1, 6'h1A, ST_RELEASE,  8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
      vecs[4]  = mk("rel_second",    2'd0, 6'h1A, 1'b0, 1'b1, 1'b1, 6'h1A, ST_WAIT,     8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
      vecs[5]  = mk("ack_repress",   2'd1, 6'h1A, 1'b1, 1'b1, 1'b1, 6'h1A, ST_DEBOUNCE, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
      vecs[6]  = mk("reaccept",      2'd0, 6'h1A, 1'b0, 1'b1, 1'b1, 6'h1A, ST_HELD,     8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
      vecs[7]  = mk("rel_one_ack",   2'd2, 6'h1A, 1'b1, 1'b1, 1'b1, 6'h1A, ST_RELEASE,  8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
      vecs[8]  = mk("repress_held",  2'd1, 6'h1A, 1'b0, 1'b1, 1'b1, 6'h1A, ST_HELD,     8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
      vecs[9]  = mk("rel_a",         2'd2, 6'h1A, 1'b0, 1'b1, 1'b1, 6'h1A, ST_RELEASE,  8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
      vecs[10] = mk("rel_b",         2'd0, 6'h1A, 1'b0, 1'b1, 1'b1, 6'h1A, ST_WAIT,     8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
      vecs[11] = mk("bounce_hit",    2'd1, 6'h1A, 1'b0, 1'b1, 1'b0, 6'h1A, ST_DEBOUNCE, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[12] = mk("bounce_rej",    2'd2, 6'h1A, 1'b0, 1'b1, 1'b0, 6'h1A, ST_WAIT,     8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[13] = mk("k05_press",     2'd1, 6'h05, 1'b0, 1'b1, 1'b0, 6'h05, ST_DEBOUNCE, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[14] = mk("k05_accept",    2'd0, 6'h05, 1'b0, 1'b1, 1'b0, 6'h05, ST_HELD,     8'h05, 1'b1, 1'b0, 1'b1, 1'b0);
      vecs[15] = mk("k05_rel1",      2'd2, 6'h05, 1'b0, 1'b1, 1'b0, 6'h05, ST_RELEASE,  8'h05, 1'b1, 1'b0, 1'b1, 1'b0);
      vecs[16] = mk("k05_rel2",      2'd0, 6'h05, 1'b0, 1'b1, 1'b0, 6'h05, ST_WAIT,     8'h05, 1'b0, 1'b0, 1'b1, 1'b0);
      vecs[17] = mk("k06_press",     2'd1, 6'h06, 1'b0, 1'b1, 1'b0, 6'h06, ST_DEBOUNCE, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0);
      vecs[18] = mk("k06_ovrun",     2'd0, 6'h06, 1'b0, 1'b1, 1'b0, 6'h06, ST_HELD,     8'h06, 1'b1, 1'b0, 1'b1, 1'b1);
      vecs[19] = mk("ovrun_clear",   2'd0, 6'h06, 1'b0, 1'b1, 1'b0, 6'h07, ST_HELD,     8'h06, 1'b1, 1'b0, 1'b1, 1'b0);
      vecs[20] = mk("k06_rel1",      2'd2, 6'h06, 1'b0, 1'b1, 1'b0, 6'h06, ST_RELEASE,  8'h06, 1'b1, 1'b0, 1'b1, 1'b0);
      vecs[21] = mk("k06_rel2",      2'd0, 6'h06, 1'b0, 1'b1, 1'b0, 6'h06, ST_WAIT,     8'h06, 1'b0, 1'b0, 1'b1, 1'b0);
      vecs[22] = mk("k07_ack_press", 2'd1, 6'h07, 1'b1, 1'b1, 1'b0, 6'h07, ST_DEBOUNCE, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[23] = mk("k07_accept",    2'd0, 6'h07, 1'b0, 1'b1, 1'b0, 6'h07, ST_HELD,     8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
      vecs[24] = mk("k07_rel1",      2'd2, 6'h07, 1'b0, 1'b1, 1'b0, 6'h07, ST_RELEASE,  8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
      vecs[25] = mk("k07_rel2",      2'd0, 6'h07, 1'b0, 1'b1, 1'b0, 6'h07, ST_WAIT,     8'h07, 1'b0, 1'b0, 1'b1, 1'b0);
      vecs[26] = mk("k21_press_ack", 2'd1, 6'h21, 1'b1, 1'b0, 1'b0, 6'h1F, ST_WAIT,     8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[27] = mk("k20_nodbn",     2'd1, 6'h20, 1'b0, 1'b0, 1'b0, 6'h20, ST_HELD,     8'h20, 1'b1, 1'b0, 1'b1, 1'b0);
      vecs[28] = mk("k21_blocked",   2'd0, 6'h21, 1'b0, 1'b0, 1'b0, 6'h21, ST_HELD,     8'h20, 1'b1, 1'b0, 1'b1, 1'b0);
      vecs[29] = mk("k21_blk_scan",  2'd0, 6'h21, 1'b0, 1'b0, 1'b0, 6'h21, ST_HELD,     8'h20, 1'b1, 1'b0, 1'b1, 1'b0);
      vecs[30] = mk("k20_rel_nodbn", 2'd2, 6'h20, 1'b0, 1'b0, 1'b0, 6'h20, ST_WAIT,     8'h20, 1'b0, 1'b0, 1'b1, 1'b0);
      vecs[31] = mk("k21_accept",    2'd0, 6'h21, 1'b0, 1'b0, 1'b0, 6'h21, ST_HELD,     8'h21, 1'b1, 1'b0, 1'b1, 1'b1);

      // Reset state
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      rst_on = 1'b0;
      check_all("reset", ST_WAIT, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00);

      for (int i = 0; i < NVEC; i++) begin
         if (vecs[i].op == 2'd1) keys[vecs[i].key] = 1'b1;
         if (vecs[i].op == 2'd2) keys[vecs[i].key] = 1'b0;
         dbn_on   = vecs[i].dbn;
         shift_on = vecs[i].shift;
         run_to(vecs[i].upto, vecs[i].ack);
         check_all(vecs[i].name, vecs[i].e_state, vecs[i].e_kbcode, vecs[i].e_kd,
                   vecs[i].e_ks, vecs[i].e_irq, vecs[i].e_ovr, k_model);
      end

      // scanEn drop while HELD: scan and key state cleared, KBCODE and IRQ kept
      scan_en = 1'b0;
      cyc(1'b1, 1'b0);
      check_all("scan_drop", ST_WAIT, 8'h21, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00);

      // Reset with enn low in the middle of a debounce
      keys = '0;
      keys[6'h1A] = 1'b1;
      scan_en = 1'b1;
      dbn_on  = 1'b1;
      run_to(6'h1A, 1'b0);
      chk("pre_reset.state", 32'(kif.state), 32'(ST_DEBOUNCE));
      rst_on = 1'b1;
      cyc(1'b0, 1'b0);
      rst_on = 1'b0;
      check_all("mid_dbn_reset", ST_WAIT, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00);

      // CTRL latched at scan slot 0, no debounce, key on the last slot then wrap
      keys = '0;
      keys[6'h3F] = 1'b1;
      ctrl_on  = 1'b1;
      shift_on = 1'b0;
      dbn_on   = 1'b0;
      run_to(6'h3F, 1'b0);
      check_all("ctrl_key3f", ST_HELD, 8'hBF, 1'b1, 1'b0, 1'b1, 1'b0, 6'h00);

      // irqAck acts without an enn tick
      cyc(1'b0, 1'b1);
      check_all("bare_ack", ST_HELD, 8'hBF, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
